// File: rtl/opcode_timing_sequencer_pkg.sv
// Shared types and default sizing for the opcode timing sequencer.
package opcode_timing_sequencer_pkg;

   localparam int OPW_DEF = 3;
   localparam int NT_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/opcode_timing_sequencer_onehot_decoder.sv
// Binary-to-one-hot decoder; every code of an OPW-bit field maps to a bit.
module opcode_timing_sequencer_onehot_decoder #(
   parameter int OPW = 3
) (
   input  logic [OPW-1:0]      code,
   output logic [2**OPW-1:0]   onehot
);

   // Set the single bit selected by the code.
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      onehot       = '0;
      onehot[code] = 1'b1;
   end

endmodule

// File: rtl/opcode_timing_sequencer.sv
// Instruction timing sequencer: accepts an opcode, decodes it one-hot onto D,
// and walks a one-hot timing step T until the datapath ends the instruction.
// Running past the last step parks the sequencer in a sticky fault state.
module opcode_timing_sequencer
   import opcode_timing_sequencer_pkg::*;
#(
   parameter int OPW = OPW_DEF,
   parameter int NT  = NT_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IR_VALID,
   output logic               IR_READY,
   input  logic [OPW-1:0]     IR_OPCODE,
   input  logic               HOLD,
   input  logic               END_INSTR,
   input  logic               FAULT_CLR,
   output logic [2**OPW-1:0]  D,
   output logic [NT-1:0]      T,
   output logic               BUSY,
   output logic               FAULT
);

   localparam logic [NT-1:0] T_FIRST = {{(NT-1){1'b0}}, 1'b1};

   state_t              state_q, state_n;
   logic [2**OPW-1:0]   d_q, d_n, dec;
   logic [NT-1:0]       t_q, t_n;
   logic                busy_q, fault_q;
   logic                accept;

   opcode_timing_sequencer_onehot_decoder #(.OPW(OPW)) u_dec (
      .code   (IR_OPCODE),
      .onehot (dec)
   );

   // Ready is a pure state decode so fetch sees it without a register delay.
   assign IR_READY = (state_q == ST_IDLE);
   assign accept   = IR_VALID & IR_READY;

   // Next state and next registered outputs; END_INSTR takes priority over HOLD.
   always_comb begin
      state_n = state_q;
      d_n     = d_q;
      t_n     = t_q;
      case (state_q)
         ST_IDLE: begin
            d_n = '0;
            t_n = '0;
            if (accept) begin
               state_n = ST_RUN;
               d_n     = dec;
               t_n     = T_FIRST;
            end
         end
         ST_RUN: begin
            if (END_INSTR) begin
               state_n = ST_IDLE;
               d_n     = '0;
               t_n     = '0;
            end else if (!HOLD) begin
               if (t_q[NT-1]) begin
                  // No wrap: stepping past the last slot is an overrun.
                  state_n = ST_FAULT;
                  t_n     = '0;
               end else begin
                  t_n = {t_q[NT-2:0], 1'b0};
               end
            end
         end
         ST_FAULT: begin
            // D is kept so the offending opcode can be inspected.
            t_n = '0;
            if (FAULT_CLR) begin
               state_n = ST_IDLE;
               d_n     = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            d_n     = '0;
            t_n     = '0;
         end
      endcase
   end

   // State and output registers; synchronous reset overrides every other input.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments let all registers update from the same pre-edge values.
      if (RST) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         t_q     <= '0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_n;
         d_q     <= d_n;
         t_q     <= t_n;
         busy_q  <= (state_n == ST_RUN);
         fault_q <= (state_n == ST_FAULT);
      end
   end

   assign D     = d_q;
   assign T     = t_q;
   assign BUSY  = busy_q;
   assign FAULT = fault_q;

endmodule

// File: tb/tb_opcode_timing_sequencer.sv
// Scoreboard bench for opcode_timing_sequencer: default build (A) and
// OPW=4/NT=4 build (B). Drivers push expected outputs; monitors pop and compare.
module tb_opcode_timing_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Build A: OPW=3, NT=8
   logic       rst_a = 1'b1, v_a = 1'b0, h_a = 1'b0, e_a = 1'b0, c_a = 1'b0;
   logic [2:0] op_a = '0;
   logic       rdy_a, busy_a, flt_a;
   logic [7:0] d_a, t_a;

   // Build B: OPW=4, NT=4
   logic        rst_b = 1'b1, v_b = 1'b0, h_b = 1'b0, e_b = 1'b0, c_b = 1'b0;
   logic [3:0]  op_b = '0;
   logic        rdy_b, busy_b, flt_b;
   logic [15:0] d_b;
   logic [3:0]  t_b;

   opcode_timing_sequencer dut_a (
      .CLK(clk), .RST(rst_a), .IR_VALID(v_a), .IR_READY(rdy_a), .IR_OPCODE(op_a),
      .HOLD(h_a), .END_INSTR(e_a), .FAULT_CLR(c_a), .D(d_a), .T(t_a),
      .BUSY(busy_a), .FAULT(flt_a)
   );

   opcode_timing_sequencer #(.OPW(4), .NT(4)) dut_b (
      .CLK(clk), .RST(rst_b), .IR_VALID(v_b), .IR_READY(rdy_b), .IR_OPCODE(op_b),
      .HOLD(h_b), .END_INSTR(e_b), .FAULT_CLR(c_b), .D(d_b), .T(t_b),
      .BUSY(busy_b), .FAULT(flt_b)
   );

   // Expected output vector layout: {ready, d[15:0], t[7:0], busy, fault}
   typedef struct {
      logic [26:0] v;
      string       nm;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [26:0] ex(logic rdy, logic [15:0] d, logic [7:0] t, logic b, logic f);
      return {rdy, d, t, b, f};
   endfunction

   function automatic logic [26:0] idle_e();
      return ex(1'b1, 16'h0, 8'h0, 1'b0, 1'b0);
   endfunction

   function automatic logic [26:0] run_e(logic [15:0] d, logic [7:0] t);
      return ex(1'b0, d, t, 1'b1, 1'b0);
   endfunction

   function automatic logic [26:0] flt_e(logic [15:0] d);
      return ex(1'b0, d, 8'h0, 1'b0, 1'b1);
   endfunction

   task automatic check(input string nm, input logic [26:0] act, input logic [26:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got rdy=%b d=%h t=%h busy=%b fault=%b, want rdy=%b d=%h t=%h busy=%b fault=%b",
                  nm, act[26], act[25:10], act[9:2], act[1], act[0],
                  req[26], req[25:10], req[9:2], req[1], req[0]);
      end
   endtask

   // Drive one cycle of A inputs and queue the outputs expected after the edge.
   task automatic step_a(input logic r, input logic v, input logic [2:0] op, input logic h,
                         input logic e, input logic c, input logic [26:0] exv, input string nm);
      exp_t x;
      @(negedge clk);
      rst_a = r; v_a = v; op_a = op; h_a = h; e_a = e; c_a = c;
      x.v = exv; x.nm = nm;
      q_a.push_back(x);
      @(posedge clk);
   endtask

   task automatic step_b(input logic r, input logic v, input logic [3:0] op, input logic h,
                         input logic e, input logic c, input logic [26:0] exv, input string nm);
      exp_t x;
      @(negedge clk);
      rst_b = r; v_b = v; op_b = op; h_b = h; e_b = e; c_b = c;
      x.v = exv; x.nm = nm;
      q_b.push_back(x);
      @(posedge clk);
   endtask

   // Monitors: sample shortly after each rising edge, compare against queued expectation.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q_a.size() > 0) begin
         x = q_a.pop_front();
         check(x.nm, {rdy_a, 8'h00, d_a, t_a, busy_a, flt_a}, x.v);
      end
   end

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q_b.size() > 0) begin
         x = q_b.pop_front();
         check(x.nm, {rdy_b, d_b, 4'h0, t_b, busy_b, flt_b}, x.v);
      end
   end

   initial begin
      // ---------------- Build A ----------------
      step_a(1, 0, 3'd0, 0, 0, 0, idle_e(),                  "a_reset");
      // Accept opcode 5
      step_a(0, 1, 3'd5, 0, 0, 0, run_e(16'h20, 8'h01),      "a_accept_op5");
      // One-step instruction then immediate back-to-back accept
      step_a(0, 0, 3'd0, 0, 1, 0, idle_e(),                  "a_end_at_t0");
      step_a(0, 1, 3'd2, 0, 0, 0, run_e(16'h04, 8'h01),      "a_accept_op2");
      step_a(0, 1, 3'd6, 0, 0, 1, run_e(16'h04, 8'h02),      "a_walk_t1_ignore_valid_clr");
      step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h04, 8'h04),      "a_walk_t2");
      step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h04, 8'h08),      "a_walk_t3");
      step_a(0, 0, 3'd0, 0, 1, 0, idle_e(),                  "a_end_at_t3");
      // Stray controls in IDLE do nothing
      step_a(0, 0, 3'd0, 1, 1, 1, idle_e(),                  "a_idle_stray_ctl");
      // Hold for three cycles at T2, then end with HOLD still high
      step_a(0, 1, 3'd6, 0, 0, 0, run_e(16'h40, 8'h01),      "a_accept_op6");
      step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h40, 8'h02),      "a_hold_walk_t1");
      step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h40, 8'h04),      "a_hold_walk_t2");
      for (int i = 0; i < 3; i++)
         step_a(0, 0, 3'd0, 1, 0, 0, run_e(16'h40, 8'h04),   "a_hold_t2");
      step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h40, 8'h08),      "a_release_t3");
      step_a(0, 0, 3'd0, 1, 1, 0, idle_e(),                  "a_end_beats_hold");
      // Overrun into FAULT
      step_a(0, 1, 3'd7, 0, 0, 0, run_e(16'h80, 8'h01),      "a_accept_op7");
      for (int k = 1; k < 8; k++)
         step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h80, 8'h01 << k), "a_overrun_walk");
      step_a(0, 0, 3'd0, 0, 0, 0, flt_e(16'h80),             "a_fault_entry");
      step_a(0, 1, 3'd1, 0, 0, 0, flt_e(16'h80),             "a_fault_ignores_valid");
      step_a(0, 0, 3'd0, 1, 1, 0, flt_e(16'h80),             "a_fault_ignores_end_hold");
      step_a(0, 0, 3'd0, 0, 0, 1, idle_e(),                  "a_fault_clr");
      step_a(0, 1, 3'd0, 0, 0, 0, run_e(16'h01, 8'h01),      "a_accept_op0");
      step_a(0, 0, 3'd0, 0, 1, 0, idle_e(),                  "a_end_op0");
      // Reset at T5 with END_INSTR and IR_VALID also high
      step_a(0, 1, 3'd3, 0, 0, 0, run_e(16'h08, 8'h01),      "a_accept_op3");
      for (int k = 1; k < 6; k++)
         step_a(0, 0, 3'd0, 0, 0, 0, run_e(16'h08, 8'h01 << k), "a_walk_to_t5");
      step_a(1, 1, 3'd4, 0, 1, 0, idle_e(),                  "a_rst_dominates");
      step_a(0, 0, 3'd0, 0, 0, 0, idle_e(),                  "a_after_rst");

      // ---------------- Build B ----------------
      step_b(1, 0, 4'h0, 0, 0, 0, idle_e(),                  "b_reset");
      step_b(0, 1, 4'hF, 0, 0, 0, run_e(16'h8000, 8'h01),    "b_accept_opF");
      step_b(0, 0, 4'h0, 0, 0, 0, run_e(16'h8000, 8'h02),    "b_walk_t1");
      step_b(0, 0, 4'h0, 0, 0, 0, run_e(16'h8000, 8'h04),    "b_walk_t2");
      step_b(0, 0, 4'h0, 0, 0, 0, run_e(16'h8000, 8'h08),    "b_walk_t3");
      step_b(0, 0, 4'h0, 0, 0, 0, flt_e(16'h8000),           "b_overrun_fault");
      step_b(1, 0, 4'h0, 0, 0, 1, idle_e(),                  "b_rst_in_fault");
      step_b(0, 0, 4'h0, 0, 0, 0, idle_e(),                  "b_after_rst");

      // Drain both scoreboards with a bounded wait.
      for (int w = 0; w < 20 && (q_a.size() > 0 || q_b.size() > 0); w++)
         @(negedge clk);
      if (q_a.size() > 0 || q_b.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d/%0d expectations left, want 0/0", q_a.size(), q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/opcode_timing_sequencer.md
OPCODE_TIMING_SEQUENCER -- requirements
Module: opcode_timing_sequencer

Interface
REQ-001 Parameter OPW, default 3, opcode width in bits; legal range 1..6.
REQ-002 Parameter NT, default 8, number of timing steps T0..T(NT-1); legal range 2..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 IR_VALID  input  1  opcode offered by fetch stage.
REQ-006 IR_READY  output  1  sequencer able to accept an opcode.
REQ-007 IR_OPCODE  input  OPW  opcode field; sampled only on accept.
REQ-008 HOLD  input  1  stall; freezes timing step while asserted.
REQ-009 END_INSTR  input  1  datapath signals final step of current instruction.
REQ-010 FAULT_CLR  input  1  clears the fault state.
REQ-011 D  output  2**OPW  registered one-hot decode of the latched opcode.
REQ-012 T  output  NT  registered one-hot current timing step.
REQ-013 BUSY  output  1  instruction in progress.
REQ-014 FAULT  output  1  step overrun detected.

Function
REQ-015 FSM states: IDLE, RUN, FAULT; encoding free, one state active at a time.
REQ-016 IR_READY SHALL equal 1 only in IDLE; purely decoded from state.
REQ-017 Accept = IR_VALID & IR_READY; on accept, opcode latched, D = 1 << IR_OPCODE, T = T0, state -> RUN, next cycle.
REQ-018 IR_VALID without IR_READY SHALL be ignored; no opcode latched.
REQ-019 In IDLE, D and T SHALL be all-zero; BUSY = 0.
REQ-020 In RUN, BUSY = 1, D holds latched one-hot value unchanged, exactly one bit of T set.
REQ-021 In RUN, HOLD=0 and END_INSTR=0: T shifts one position (Tk -> Tk+1) per cycle.
REQ-022 In RUN, HOLD=1 and END_INSTR=0: T and D unchanged.
REQ-023 In RUN, END_INSTR=1 (regardless of HOLD): next cycle state IDLE, D=0, T=0; end wins over hold.
REQ-024 In RUN at T(NT-1), HOLD=0, END_INSTR=0: no wrap; state -> FAULT next cycle.
REQ-025 In FAULT: FAULT=1, BUSY=0, IR_READY=0, D keeps latched opcode for diagnosis, T=0.
REQ-026 FAULT persists until FAULT_CLR=1 (-> IDLE next cycle) or RST.
REQ-027 FAULT_CLR, END_INSTR, HOLD outside their relevant states SHALL have no effect.
REQ-028 Minimum instruction length 1 step: END_INSTR during T0 returns to IDLE; back-to-back accept possible one cycle after return (IDLE lasts >=1 cycle).
REQ-029 Out-of-range opcode impossible for power-of-two decode; all 2**OPW codes decode.

Reset
REQ-030 RST SHALL dominate all other inputs in the same cycle, including accept and END_INSTR.
REQ-031 After RST: state IDLE, D=0, T=0, BUSY=0, FAULT=0, IR_READY=1 on following cycle.
REQ-032 RST mid-instruction or in FAULT SHALL abandon state without completing; no output glitch beyond one-cycle transition.

Structure
REQ-033 Shared package holds FSM state typedef and default constants OPW_DEF=3, NT_DEF=8.
REQ-034 One sub-module natural: onehot_decoder (parametrised OPW -> 2**OPW), reused for D generation.
REQ-035 All outputs registered except IR_READY (state decode).

Verification
REQ-036 Reset then IR_VALID=1, IR_OPCODE=3'b101 -> next cycle D=8'b00100000, T=8'b00000001, BUSY=1, IR_READY=0.
REQ-037 Opcode 3'b010 accepted, no HOLD, END_INSTR at T3 -> T walks 0x01,0x02,0x04,0x08, then IDLE with D=0, T=0.
REQ-038 HOLD asserted 3 cycles at T2 -> T stays 0x04 for 3 cycles, then 0x08; END_INSTR with HOLD=1 at T3 -> IDLE.
REQ-039 No END_INSTR for 8 steps -> cycle after T=0x80 FAULT=1, D retains opcode, IR_VALID ignored; FAULT_CLR -> IDLE.
REQ-040 RST asserted at T5 with END_INSTR and IR_VALID also high -> next cycle all outputs zero, IR_READY=1.
REQ-041 OPW=4, NT=4 build: opcode 4'hF -> D=16'h8000; overrun after T3 -> FAULT.
